spu_uart_rx: RTL and testbench
==============================

// Module: spu_uart_rx
// PURPOSE
//  8N1 UART receiver with 16x oversampling, the receive-side counterpart of the SoC txd transmit path.
//  Samples the asynchronous rxd pin and deframes bytes LSB-first.
//  Presents each byte to the CPU/MMU side through a one-entry valid/ready holding register.
//  Reports framing-error and overrun status.
// PARAMETERS
//  DIVISOR     54   clk cycles per oversample tick (100 MHz / (115200*16) ~= 54); legal range >= 2
//  OVERSAMPLE  16   ticks per bit; fixed at 16, sample ticks are 7/8/9
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active-low (0 = reset)
//  rxd         in   1  serial input, idle high, asynchronous to clk
//  rx_data     out  8  received byte; stable while rx_valid=1
//  rx_valid    out  1  rx_data/rx_ferr hold an unconsumed byte
//  rx_ready    in   1  consumer accepts the byte when rx_valid & rx_ready
//  rx_ferr     out  1  framing error (stop bit sampled 0) for the byte in rx_data
//  rx_overrun  out  1  sticky: a completed byte was dropped because the holding register was full
//  ovr_clr     in   1  single-cycle pulse that clears rx_overrun
//  rx_busy     out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): rx_data=0, rx_valid=0, rx_ferr=0, rx_overrun=0, rx_busy=0.
//   FSM returns to IDLE; both synchronizer flops load 1; tick and bit counters clear to 0.
//  Reset mid-frame: the partial byte is discarded; no rx_valid is produced after release.
//  Synchronizer: 2-flop; all decisions use the second flop (rxs). Adds 2 clk of input latency.
//  Tick generator: free-running counter 0..DIVISOR-1; tick=1 for one clk when the count = DIVISOR-1.
//  Sample counter: 4 bits, advances on tick only. Majority vote = 2 of 3 rxs samples taken at sample counts 7, 8, 9.
//  FSM (all state changes occur on tick):
//   IDLE:  rxs=0 on a tick -> START, sample count = 0. Otherwise stay.
//   START: vote decided at count 9.
//    - vote=1 (glitch) -> IDLE; no output, no error.
//    - vote=0 -> continue; at count 15 -> DATA, bit index = 0.
//   DATA:  vote shifted in LSB-first at count 9. At count 15: bit index 7 -> STOP, otherwise index+1.
//   STOP:  vote decided at count 9; the byte is delivered on the next clk (see Delivery).
//    - vote=1 -> IDLE.
//    - vote=0 -> BRK.
//   BRK:   stay until rxs=1 on a tick, then IDLE. No start detection while in BRK.
//  Delivery: 1 clk after the STOP vote tick the completed byte goes to the holding register.
//   - Loaded when rx_valid=0, or when rx_valid=1 & rx_ready=1 in that same cycle.
//     Loads rx_data, sets rx_ferr = ~vote, rx_valid stays/becomes 1.
//   - Otherwise the byte is dropped, rx_overrun is set to 1, and rx_data/rx_ferr are unchanged.
//  Handshake: rx_valid & rx_ready with no simultaneous load -> rx_valid=0 next clk.
//   rx_data/rx_ferr hold their last values.
//  rx_ready while rx_valid=0 has no effect.
//  rx_overrun: set by a drop, cleared by ovr_clr. A drop in the same cycle as ovr_clr wins: flag stays 1.
//  Frame length: 10 bit periods = 160 ticks from start detect to the end of the stop bit.
//   The next start can be detected on the tick after the STOP vote; a receiver 6 ticks ahead of the sender tolerates ~3.7% baud error.
//  rx_busy = (state != IDLE); combinational from the state register.
// TESTING
//  (all cases DIVISOR=4, bit period = 64 clk)
//  1. Reset: hold rst=0 with rxd toggling -> all outputs 0; after release with rxd=1 idle, rx_valid stays 0 for 1000 clk.
//  2. Single byte: send 0xA5 with rx_ready=0.
//     -> rx_valid=1, rx_data=0xA5, rx_ferr=0 within 2 ticks after the stop mid-point.
//     Pulse rx_ready -> rx_valid=0 next clk.
//  3. Overrun: send 0xA5 then 0x3C with rx_ready=0 throughout -> rx_data stays 0xA5, rx_overrun=1.
//     Pulse ovr_clr -> rx_overrun=0.
//     Repeat with rx_ready=1 held -> both bytes delivered, rx_overrun=0.
//  4. Glitch: drive rxd=0 for 3 ticks (12 clk), then 1 -> FSM returns to IDLE, rx_valid never asserts.
//  5. Framing/break: send 0x55 with stop=0 and hold rxd=0 for 3 bit periods.
//     -> rx_data=0x55, rx_ferr=1, no further byte.
//     Release rxd=1, then send 0x0F -> rx_data=0x0F, rx_ferr=0.
//  6. Reset mid-frame: assert rst=0 during data bit 4 of 0xFF, then release with rxd=1.
//     -> rx_valid=0, rx_busy=0; a following 0x81 is received correctly.

Source files
------------

// File: rtl/spu_uart_rx.sv
// spu_uart_rx: 8N1 UART receiver with 16x oversampling.
// A 2-flop synchronizer feeds a tick-driven deframing FSM that takes a 2-of-3
// majority vote at sample counts 7/8/9 of every bit. Completed bytes are handed
// to a one-entry valid/ready holding register that reports framing errors and
// latches a sticky overrun flag when a byte arrives while the register is full.
module spu_uart_rx #(
  parameter int DIVISOR    = 54,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_ferr,
  output logic       rx_overrun,
  input  logic       ovr_clr,
  output logic       rx_busy
);

  localparam int         DIV_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t             state;
  logic               rxs_p0;
  logic               rxs;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [3:0]         samp_cnt;
  logic [2:0]         bit_idx;
  logic [1:0]         samp_hist;
  logic [7:0]         shift;
  logic               vote;
  logic               vld_p1;
  logic               ferr_p1;
  logic               load;
  logic               drop;

  // 2-of-3 majority of the samples taken at counts 7, 8 and 9
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick    = (div_cnt == DIV_W'(DIVISOR - 1));
  assign vote    = maj3(samp_hist[1], samp_hist[0], rxs);
  assign rx_busy = (state != S_IDLE);
  assign load    = vld_p1 & (~rx_valid | rx_ready);
  assign drop    = vld_p1 & rx_valid & ~rx_ready;

  // Synchronize the asynchronous serial input; idle level is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs_p0 <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxs_p0 <= rxd;
      rxs    <= rxs_p0;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Deframing FSM; every state change happens on a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      samp_cnt <= 4'd0;
      bit_idx  <= 3'd0;
      vld_p1   <= 1'b0;
      ferr_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rxs) begin
              state    <= S_START;
              samp_cnt <= 4'd0;
            end
          end
          S_START: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd9 && vote) begin
              state <= S_IDLE;
            end else if (samp_cnt == LAST_CNT) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end
          end
          S_DATA: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == LAST_CNT) begin
              if (bit_idx == 3'd7) begin
                state <= S_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
          S_STOP: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd9) begin
              vld_p1  <= 1'b1;
              ferr_p1 <= ~vote;
              state   <= vote ? S_IDLE : S_BRK;
            end
          end
          S_BRK: begin
            if (rxs) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Sample history and LSB-first data shift register
  always_ff @(posedge clk) begin
    if (tick && state != S_IDLE && state != S_BRK) begin
      if (samp_cnt == 4'd7) samp_hist[1] <= rxs;
      if (samp_cnt == 4'd8) samp_hist[0] <= rxs;
      if (state == S_DATA && samp_cnt == 4'd9) shift <= {vote, shift[7:1]};
    end
  end

  // One-entry holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift;
        rx_ferr  <= ferr_p1;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (drop) begin
        rx_overrun <= 1'b1;
      end else if (ovr_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spu_uart_rx.sv
// tb_spu_uart_rx: scoreboard bench for the 8N1 UART receiver at DIVISOR=4.
module tb_spu_uart_rx;

  localparam int DIV     = 4;
  localparam int BIT_CLK = DIV * 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ferr;
  logic       rx_overrun;
  logic       ovr_clr;
  logic       rx_busy;

  int         checks = 0;
  int         passed = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_mem[0:15];
  int         got_wr  = 0;
  int         got_rd  = 0;
  int         vld_cnt = 0;

  spu_uart_rx #(.DIVISOR(DIV), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .rx_overrun (rx_overrun),
    .ovr_clr    (ovr_clr),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  // Capture every accepted byte ({ferr, data}) half a cycle before its handshake edge
  always @(negedge clk) begin
    if (rx_valid) vld_cnt++;
    if (rx_valid && rx_ready) begin
      got_mem[got_wr % 16] = {rx_ferr, rx_data};
      got_wr++;
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    clk_n(BIT_CLK);
  endtask

  task automatic tx_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    clk_n(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    int v0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rxd = ~rxd;
      clk_n(1);
    end
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_data); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_valid); else passed++;
    checks++; if (rx_ferr !== 1'b0) $display("FAIL reset_ferr got %b exp 0", rx_ferr); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", rx_overrun); else passed++;
    checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", rx_busy); else passed++;
    rxd = 1'b1;
    clk_n(1);
    rst = 1'b1;
    v0 = vld_cnt;
    clk_n(1000);
    @(negedge clk);
    checks++; if (vld_cnt !== v0) $display("FAIL idle_valid got %0d valid cycles exp 0", vld_cnt - v0); else passed++;
    checks++; if (rx_busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", rx_busy); else passed++;
  endtask

  task automatic test_single();
    logic [8:0] e, g;
    rx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    tx_frame(8'hA5, 1'b1);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", rx_valid); else passed++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL single_data got %h exp a5", rx_data); else passed++;
    checks++; if (rx_ferr !== 1'b0) $display("FAIL single_ferr got %b exp 0", rx_ferr); else passed++;
    pulse_ready();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL single_consume got %b exp 0", rx_valid); else passed++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL single_hold got %h exp a5", rx_data); else passed++;
    checks++;
    if (got_wr - got_rd !== exp_q.size()) $display("FAIL single_count got %0d exp %0d", got_wr - got_rd, exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      e = exp_q.pop_front();
      g = got_mem[got_rd % 16];
      got_rd++;
      checks++; if (g !== e) $display("FAIL single_byte got %h exp %h", g, e); else passed++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  task automatic test_overrun();
    logic [8:0] e, g;
    rx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    tx_frame(8'hA5, 1'b1);
    tx_frame(8'h3C, 1'b1);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", rx_valid); else passed++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL ovr_data got %h exp a5", rx_data); else passed++;
    checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", rx_overrun); else passed++;
    ovr_clr = 1'b1;
    clk_n(1);
    ovr_clr = 1'b0;
    @(negedge clk);
    checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", rx_overrun); else passed++;
    pulse_ready();
    rx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h3C});
    tx_frame(8'hA5, 1'b1);
    tx_frame(8'h3C, 1'b1);
    clk_n(4);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_ready_flag got %b exp 0", rx_overrun); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_ready_valid got %b exp 0", rx_valid); else passed++;
    checks++;
    if (got_wr - got_rd !== exp_q.size()) $display("FAIL ovr_count got %0d exp %0d", got_wr - got_rd, exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      e = exp_q.pop_front();
      g = got_mem[got_rd % 16];
      got_rd++;
      checks++; if (g !== e) $display("FAIL ovr_byte got %h exp %h", g, e); else passed++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  task automatic test_glitch();
    int v0;
    rx_ready = 1'b0;
    v0 = vld_cnt;
    rxd = 1'b0;
    clk_n(10);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_start got %b exp 1", rx_busy); else passed++;
    clk_n(2);
    rxd = 1'b1;
    clk_n(200);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle got %b exp 0", rx_busy); else passed++;
    checks++; if (vld_cnt !== v0) $display("FAIL glitch_valid got %0d valid cycles exp 0", vld_cnt - v0); else passed++;
  endtask

  task automatic test_break();
    logic [8:0] e, g;
    rx_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h55});
    tx_frame(8'h55, 1'b0);
    rxd = 1'b0;
    clk_n(3 * BIT_CLK);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) $display("FAIL brk_valid got %b exp 1", rx_valid); else passed++;
    checks++; if (rx_data !== 8'h55) $display("FAIL brk_data got %h exp 55", rx_data); else passed++;
    checks++; if (rx_ferr !== 1'b1) $display("FAIL brk_ferr got %b exp 1", rx_ferr); else passed++;
    checks++; if (rx_busy !== 1'b1) $display("FAIL brk_busy got %b exp 1", rx_busy); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL brk_overrun got %b exp 0", rx_overrun); else passed++;
    rxd = 1'b1;
    clk_n(BIT_CLK);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) $display("FAIL brk_release got %b exp 0", rx_busy); else passed++;
    pulse_ready();
    exp_q.push_back({1'b0, 8'h0F});
    tx_frame(8'h0F, 1'b1);
    @(negedge clk);
    checks++; if (rx_data !== 8'h0F) $display("FAIL brk_next_data got %h exp 0f", rx_data); else passed++;
    checks++; if (rx_ferr !== 1'b0) $display("FAIL brk_next_ferr got %b exp 0", rx_ferr); else passed++;
    pulse_ready();
    @(negedge clk);
    checks++;
    if (got_wr - got_rd !== exp_q.size()) $display("FAIL brk_count got %0d exp %0d", got_wr - got_rd, exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      e = exp_q.pop_front();
      g = got_mem[got_rd % 16];
      got_rd++;
      checks++; if (g !== e) $display("FAIL brk_byte got %h exp %h", g, e); else passed++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  task automatic test_midreset();
    logic [8:0] e, g;
    rx_ready = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    clk_n(30);
    rst = 1'b0;
    clk_n(5);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", rx_busy); else passed++;
    rst = 1'b1;
    clk_n(100);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", rx_valid); else passed++;
    checks++; if (rx_busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", rx_busy); else passed++;
    rx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h81});
    tx_frame(8'h81, 1'b1);
    clk_n(4);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (got_wr - got_rd !== exp_q.size()) $display("FAIL mid_count got %0d exp %0d", got_wr - got_rd, exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      e = exp_q.pop_front();
      g = got_mem[got_rd % 16];
      got_rd++;
      checks++; if (g !== e) $display("FAIL mid_byte got %h exp %h", g, e); else passed++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  initial begin
    rst      = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    ovr_clr  = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_break();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached after %0d of %0d checks", passed, checks);
    $fatal(1, "time limit");
  end

endmodule
